// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch time counter:
//   - state_e      : control FSM state encoding
//   - BCD_W        : width of one BCD digit
//   - NUM_DIGITS   : HH:MM:SS.CC digit count
//   - digit_mod()  : modulus of each digit position, CC units first
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        LAP_RUN = 2'd3
    } state_e;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned NUM_DIGITS = 8;

    // Digit moduli: decimal digits, tens of seconds/minutes, hour digits.
    localparam int unsigned MOD_DEC  = 10;
    localparam int unsigned MOD_SEX  = 6;
    localparam int unsigned MOD_HOUR = 10;

    // Position 0 is CC units, position 7 is H tens.
    function automatic int unsigned digit_mod(input int unsigned idx);
        case (idx)
            3, 5:    return MOD_SEX;
            6, 7:    return MOD_HOUR;
            default: return MOD_DEC;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// One BCD digit of a ripple-carry chain counting 0..MOD-1.
// Ports:
//   clk          in   clock, rising edge
//   clear_i      in   synchronous clear to 0 (priority over counting)
//   inc_en_i     in   global count enable (the centisecond tick)
//   carry_in_i   in   all lower digits are at their maximum
//   digit_o      out  current digit value
//   carry_out_o  out  carry_in_i and this digit at MOD-1
// -----------------------------------------------------------------------------
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MOD = 10
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             inc_en_i,
    input  logic             carry_in_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             carry_out_o
);

    if (MOD < 2 || MOD > 10) begin : g_bad_mod
        $error("bcd_digit_counter: MOD must be within 2..10");
    end

    localparam logic [BCD_W-1:0] DIGIT_MAX = BCD_W'(MOD - 1);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    assign carry_out_o = carry_in_i && (digit_q == DIGIT_MAX);

    always_comb begin
        // NOTE: default first so every path assigns digit_d and no latch is inferred.
        digit_d = digit_q;
        if (clear_i) begin
            digit_d = '0;
        end else if (inc_en_i && carry_in_i) begin
            digit_d = carry_out_o ? '0 : digit_q + BCD_W'(1);
        end
    end

    // NOTE: non-blocking so every flop samples pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        digit_q <= digit_d;
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/stopwatch_time_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_time_counter
// Divides the board clock to a centisecond tick, keeps HH:MM:SS.CC as 8 BCD
// digits and handles start/stop, lap-freeze and clear command pulses.
// Ports:
//   clock_100Mhz  in   system clock, rising edge
//   reset         in   synchronous reset, active low
//   start_stop    in   pulse: toggle counting
//   lap           in   pulse: freeze / unfreeze displayed value
//   clear         in   pulse: zero the time (PAUSE only)
//   digits_bcd    out  displayed time, [31:28]=H tens .. [3:0]=CC units
//   running       out  RUN or LAP_RUN
//   lap_active    out  LAP_RUN
//   overflow      out  one-cycle pulse on wrap past 99:59:59.99
// -----------------------------------------------------------------------------
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic                          clock_100Mhz,
    input  logic                          reset,
    input  logic                          start_stop,
    input  logic                          lap,
    input  logic                          clear,
    output logic [NUM_DIGITS*BCD_W-1:0]   digits_bcd,
    output logic                          running,
    output logic                          lap_active,
    output logic                          overflow
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
        $error("stopwatch_time_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
    end

    state_e                        state_q, state_d;
    logic [PRE_W-1:0]              presc_q, presc_d;
    logic [NUM_DIGITS*BCD_W-1:0]   lap_q;
    logic [NUM_DIGITS*BCD_W-1:0]   live_bcd;
    logic                          ovf_q;
    logic                          run_now;
    logic                          tick;
    logic                          clr_time;
    logic                          lap_load;
    logic [NUM_DIGITS:0]           carry;

    assign run_now  = (state_q == RUN) || (state_q == LAP_RUN);
    assign tick     = run_now && (presc_q == PRE_LAST);
    // Time is zeroed by reset and by an honoured clear (PAUSE only).
    assign clr_time = !reset || ((state_q == PAUSE) && clear);

    // Control FSM; start_stop outranks lap, clear outranks start_stop.
    always_comb begin
        state_d  = state_q;
        lap_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_stop) state_d = RUN;
            end
            RUN: begin
                if (start_stop) begin
                    state_d = PAUSE;
                end else if (lap) begin
                    state_d  = LAP_RUN;
                    lap_load = 1'b1;
                end
            end
            LAP_RUN: begin
                if (start_stop)  state_d = PAUSE;
                else if (lap)    state_d = RUN;
            end
            PAUSE: begin
                if (clear)           state_d = IDLE;
                else if (start_stop) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler only advances while running; it holds in PAUSE so a resumed
    // count keeps its fractional centisecond.
    always_comb begin
        presc_d = presc_q;
        if (state_q == IDLE || clr_time) begin
            presc_d = '0;
        end else if (run_now) begin
            presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (!reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            // NOTE: lap_q is a plain register, so it takes a reset value like the rest.
            lap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            // Captures the pre-increment value when a tick lands on the lap edge.
            if (lap_load) lap_q <= live_bcd;
            ovf_q   <= tick && carry[NUM_DIGITS];
        end
    end

    // Ripple carry: a digit advances on tick when all lower digits are at max.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_counter #(
            .MOD (digit_mod(i))
        ) u_cnt (
            .clk         (clock_100Mhz),
            .clear_i     (clr_time),
            .inc_en_i    (tick),
            .carry_in_i  (carry[i]),
            .digit_o     (live_bcd[i*BCD_W +: BCD_W]),
            .carry_out_o (carry[i+1])
        );
    end

    // Outputs decode registers only, so they reflect the state after each edge.
    assign digits_bcd = (state_q == LAP_RUN) ? lap_q : live_bcd;
    assign running    = run_now;
    assign lap_active = (state_q == LAP_RUN);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_time_counter
// Directed vector table, hand-written corner sequences (wrap, tick on stop,
// tick on lap) and randomized command pulses, all compared every cycle against
// a model that tracks elapsed running cycles and derives the time arithmetically.
// -----------------------------------------------------------------------------
module tb_stopwatch_time_counter;

    localparam int unsigned CLK_HZ  = 1000;
    localparam int unsigned TICK_HZ = 100;
    localparam longint      DIV     = longint'(CLK_HZ / TICK_HZ);
    localparam longint      WRAP_CS = 64'd36_000_000;  // 100 h in centiseconds

    logic        clock_100Mhz = 1'b0;
    logic        reset        = 1'b0;
    logic        start_stop   = 1'b0;
    logic        lap          = 1'b0;
    logic        clear        = 1'b0;
    logic [31:0] digits_bcd;
    logic        running;
    logic        lap_active;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clock_100Mhz = ~clock_100Mhz;

    stopwatch_time_counter #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .start_stop   (start_stop),
        .lap          (lap),
        .clear        (clear),
        .digits_bcd   (digits_bcd),
        .running      (running),
        .lap_active   (lap_active),
        .overflow     (overflow)
    );

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_e;

    mstate_e m_state  = M_IDLE;
    longint  m_e      = 0;    // running clock cycles since last clear/reset
    longint  m_lap_cs = 0;
    bit      m_ovf    = 1'b0;

    function automatic logic [31:0] to_bcd(input longint cs);
        longint hh, mm, ss, cc;
        hh = cs / 360000;
        mm = (cs / 6000) % 60;
        ss = (cs / 100) % 60;
        cc = cs % 100;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic longint live_cs();
        return (m_e / DIV) % WRAP_CS;
    endfunction

    function automatic logic [31:0] exp_display();
        return (m_state == M_LAP) ? to_bcd(m_lap_cs) : to_bcd(live_cs());
    endfunction

    task automatic model_step(input bit r, input bit s, input bit l, input bit c);
        bit     run_now;
        longint new_e;
        if (!r) begin
            m_state  = M_IDLE;
            m_e      = 0;
            m_lap_cs = 0;
            m_ovf    = 1'b0;
        end else begin
            run_now = (m_state == M_RUN) || (m_state == M_LAP);
            new_e   = run_now ? m_e + 1 : m_e;
            m_ovf   = run_now && (new_e % DIV == 0) && ((new_e / DIV) % WRAP_CS == 0);
            case (m_state)
                M_IDLE:  if (s) m_state = M_RUN;
                M_RUN: begin
                    if (s) m_state = M_PAUSE;
                    else if (l) begin
                        m_state  = M_LAP;
                        m_lap_cs = live_cs();
                    end
                end
                M_LAP: begin
                    if (s)      m_state = M_PAUSE;
                    else if (l) m_state = M_RUN;
                end
                default: begin
                    if (c) begin
                        m_state = M_IDLE;
                        new_e   = 0;
                    end else if (s) m_state = M_RUN;
                end
            endcase
            m_e = new_e;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at negedge.
    task automatic cycle(input bit r, input bit s, input bit l, input bit c);
        reset      = r;
        start_stop = s;
        lap        = l;
        clear      = c;
        @(posedge clock_100Mhz);
        model_step(r, s, l, c);
        @(negedge clock_100Mhz);
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        check("model_display",    digits_bcd,       exp_display());
        check("model_running",    32'(running),     32'(m_state == M_RUN || m_state == M_LAP));
        check("model_lap_active", 32'(lap_active),  32'(m_state == M_LAP));
        check("model_overflow",   32'(overflow),    32'(m_ovf));
    endtask

    typedef struct {
        bit          rst_n;
        bit          ss;
        bit          lp;
        bit          clr;
        int          n;
        logic [31:0] digits;
        bit          run;
        bit          lap_a;
        bit          ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit rst_n, input bit ss, input bit lp, input bit clr,
                                input int n, input logic [31:0] digits,
                                input bit run, input bit lap_a, input bit ovf);
        vec_t v;
        v.rst_n = rst_n; v.ss = ss; v.lp = lp; v.clr = clr; v.n = n;
        v.digits = digits; v.run = run; v.lap_a = lap_a; v.ovf = ovf;
        return v;
    endfunction

    initial begin
        // Commands apply on the first of n cycles; reset is held for all n.
        //             rst ss lp clr  n      digits        run lap ovf
        vecs.push_back(mk(0, 0, 0, 0, 3,     32'h0000_0000, 0, 0, 0)); // reset state
        vecs.push_back(mk(1, 1, 0, 0, 1,     32'h0000_0000, 1, 0, 0)); // start
        vecs.push_back(mk(1, 0, 0, 0, 9,     32'h0000_0000, 1, 0, 0)); // no early tick
        vecs.push_back(mk(1, 0, 0, 0, 1,     32'h0000_0001, 1, 0, 0)); // first tick
        vecs.push_back(mk(1, 0, 0, 0, 990,   32'h0000_0100, 1, 0, 0)); // 1.00 s
        vecs.push_back(mk(1, 0, 0, 0, 4,     32'h0000_0100, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1,     32'h0000_0100, 0, 0, 0)); // pause
        vecs.push_back(mk(1, 0, 0, 0, 50,    32'h0000_0100, 0, 0, 0)); // frozen
        vecs.push_back(mk(1, 1, 0, 0, 1,     32'h0000_0100, 1, 0, 0)); // resume
        vecs.push_back(mk(1, 0, 0, 0, 4,     32'h0000_0100, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,     32'h0000_0101, 1, 0, 0)); // tick 5 after resume
        vecs.push_back(mk(1, 0, 0, 0, 220,   32'h0000_0123, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1,     32'h0000_0123, 1, 1, 0)); // lap freeze
        vecs.push_back(mk(1, 0, 0, 0, 269,   32'h0000_0123, 1, 1, 0)); // live at 1.50
        vecs.push_back(mk(1, 0, 1, 0, 1,     32'h0000_0150, 1, 0, 0)); // unfreeze
        vecs.push_back(mk(1, 0, 0, 1, 1,     32'h0000_0150, 1, 0, 0)); // clear ignored in RUN
        vecs.push_back(mk(1, 1, 0, 0, 1,     32'h0000_0150, 0, 0, 0)); // pause
        vecs.push_back(mk(1, 1, 0, 1, 1,     32'h0000_0000, 0, 0, 0)); // clear beats start
        vecs.push_back(mk(1, 0, 1, 0, 1,     32'h0000_0000, 0, 0, 0)); // lap ignored in IDLE
        vecs.push_back(mk(1, 1, 0, 0, 1,     32'h0000_0000, 1, 0, 0)); // start from zero
        vecs.push_back(mk(1, 0, 0, 0, 12340, 32'h0000_1234, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1,     32'h0000_1234, 1, 1, 0)); // LAP_RUN
        vecs.push_back(mk(0, 0, 0, 0, 1,     32'h0000_0000, 0, 0, 0)); // reset mid-lap
        vecs.push_back(mk(1, 1, 0, 0, 1,     32'h0000_0000, 1, 0, 0)); // restart
        vecs.push_back(mk(1, 0, 0, 0, 10,    32'h0000_0001, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1,     32'h0000_0001, 0, 0, 0)); // pause
        vecs.push_back(mk(1, 0, 1, 0, 1,     32'h0000_0001, 0, 0, 0)); // lap ignored in PAUSE

        @(negedge clock_100Mhz);
        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                if (k == 0) cycle(vecs[i].rst_n, vecs[i].ss, vecs[i].lp, vecs[i].clr);
                else        cycle(vecs[i].rst_n, 1'b0, 1'b0, 1'b0);
            end
            check($sformatf("vec%0d_digits", i),     digits_bcd,      vecs[i].digits);
            check($sformatf("vec%0d_running", i),    32'(running),    32'(vecs[i].run));
            check($sformatf("vec%0d_lap_active", i), 32'(lap_active), 32'(vecs[i].lap_a));
            check($sformatf("vec%0d_overflow", i),   32'(overflow),   32'(vecs[i].ovf));
        end

        // ---- wrap: preload 99:59:59.99 while paused (prescaler at 1) ----
        force dut.g_digit[0].u_cnt.digit_q = 4'd9;
        force dut.g_digit[1].u_cnt.digit_q = 4'd9;
        force dut.g_digit[2].u_cnt.digit_q = 4'd9;
        force dut.g_digit[3].u_cnt.digit_q = 4'd5;
        force dut.g_digit[4].u_cnt.digit_q = 4'd9;
        force dut.g_digit[5].u_cnt.digit_q = 4'd5;
        force dut.g_digit[6].u_cnt.digit_q = 4'd9;
        force dut.g_digit[7].u_cnt.digit_q = 4'd9;
        #1;
        release dut.g_digit[0].u_cnt.digit_q;
        release dut.g_digit[1].u_cnt.digit_q;
        release dut.g_digit[2].u_cnt.digit_q;
        release dut.g_digit[3].u_cnt.digit_q;
        release dut.g_digit[4].u_cnt.digit_q;
        release dut.g_digit[5].u_cnt.digit_q;
        release dut.g_digit[6].u_cnt.digit_q;
        release dut.g_digit[7].u_cnt.digit_q;
        m_e = (WRAP_CS - 1) * DIV + (m_e % DIV);
        check("preload_digits", digits_bcd, 32'h9959_5999);

        cycle(1, 1, 0, 0);                       // resume
        repeat (8) cycle(1, 0, 0, 0);
        check("pre_wrap_digits", digits_bcd, 32'h9959_5999);
        check("pre_wrap_overflow", 32'(overflow), 32'd0);
        cycle(1, 0, 0, 0);                       // wrapping tick
        check("wrap_digits", digits_bcd, 32'h0000_0000);
        check("wrap_overflow", 32'(overflow), 32'd1);
        check("wrap_running", 32'(running), 32'd1);
        cycle(1, 0, 0, 0);
        check("post_wrap_overflow", 32'(overflow), 32'd0);

        // ---- tick coinciding with start_stop: tick counted, then PAUSE ----
        repeat (8) cycle(1, 0, 0, 0);
        check("before_tick_stop", digits_bcd, 32'h0000_0000);
        cycle(1, 1, 0, 0);
        check("tick_stop_digits", digits_bcd, 32'h0000_0001);
        check("tick_stop_running", 32'(running), 32'd0);

        // ---- tick coinciding with lap: lap holds pre-increment value ----
        cycle(1, 1, 0, 0);
        repeat (9) cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        check("tick_lap_display", digits_bcd, 32'h0000_0001);
        check("tick_lap_active", 32'(lap_active), 32'd1);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);                       // start_stop leaves LAP_RUN
        check("lap_stop_display", digits_bcd, 32'h0000_0002);
        check("lap_stop_active", 32'(lap_active), 32'd0);
        check("lap_stop_running", 32'(running), 32'd0);

        // ---- randomized command pulses against the model ----
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 299) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
